// File: rtl/mem_arbiter_pkg.sv
// Shared state encodings, on/off constants and the fetch word selector for mem_arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        I_ACCESS = 2'd1,
        D_ACCESS = 2'd2
    } arbState_t;

    localparam logic       ON        = 1'b1;
    localparam logic       OFF       = 1'b0;
    localparam logic [7:0] ALL_LANES = 8'hFF;
    localparam logic [7:0] NO_LANES  = 8'h00;

    // Instructions are 32-bit; address bit 2 picks the half of the 64-bit bus word.
    function automatic logic [31:0] selectWord(input logic [63:0] busWord, input logic upperHalf);
        return upperHalf ? busWord[63:32] : busWord[31:0];
    endfunction

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Counts access cycles without memory ready; flags expiry on the cycle that reaches MAX_WAIT.
module mem_arbiter_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iClear,
    input  logic iEnable,
    output logic oExpire
);

    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

    logic [7:0] count;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)      count <= 8'd0;
        else if (iClear)  count <= 8'd0;
        else if (iEnable) count <= count + 8'd1;
    end

    assign oExpire = iEnable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one memory port, one access in flight,
// with a wait timeout that answers the requester with a bus error.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_PRIORITY = 1,
    parameter int MAX_WAIT      = 15
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iIReq,
    input  logic [63:0] iIAddress,
    output logic        oIAck,
    output logic [31:0] oIReadData,
    input  logic        iDReq,
    input  logic        iDWrite,
    input  logic [63:0] iDAddress,
    input  logic [63:0] iDWriteData,
    input  logic [7:0]  iDByteEnable,
    output logic        oDAck,
    output logic [63:0] oDReadData,
    output logic        oBusError,
    output logic        oMReadEnable,
    output logic        oMWriteEnable,
    output logic [63:0] oMAddress,
    output logic [63:0] oMWriteData,
    output logic [7:0]  oMByteEnable,
    input  logic [63:0] iMReadData,
    input  logic        iMReady
);

    arbState_t state;
    logic      lastData;
    logic      reqI, reqD, grant, grantD, timerEn, expire;

    // A port being acked this cycle still shows its old request; keep it out of arbitration.
    always_comb begin
        reqI    = iIReq && !oIAck;
        reqD    = iDReq && !oDAck;
        grant   = (state == IDLE) && (reqI || reqD);
        grantD  = reqD;
        if (reqI && reqD) grantD = (DATA_PRIORITY != 0) ? ON : !lastData;
        timerEn = (state != IDLE) && !iMReady;
    end

    mem_arbiter_wait_timer #(.MAX_WAIT(MAX_WAIT)) waitTimer (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iClear  (grant),
        .iEnable (timerEn),
        .oExpire (expire)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state         <= IDLE;
            lastData      <= ON;
            oIAck         <= OFF;
            oDAck         <= OFF;
            oBusError     <= OFF;
            oIReadData    <= 32'd0;
            oDReadData    <= 64'd0;
            oMReadEnable  <= OFF;
            oMWriteEnable <= OFF;
            oMAddress     <= 64'd0;
            oMWriteData   <= 64'd0;
            oMByteEnable  <= NO_LANES;
        end else begin
            oIAck     <= OFF;
            oDAck     <= OFF;
            oBusError <= OFF;
            case (state)
                IDLE: begin
                    if (grant) begin
                        lastData <= grantD;
                        if (grantD) begin
                            state         <= D_ACCESS;
                            oMAddress     <= iDAddress;
                            oMWriteData   <= iDWriteData;
                            oMReadEnable  <= !iDWrite;
                            oMWriteEnable <= iDWrite;
                            oMByteEnable  <= iDWrite ? iDByteEnable : ALL_LANES;
                        end else begin
                            state         <= I_ACCESS;
                            oMAddress     <= iIAddress;
                            oMWriteData   <= 64'd0;
                            oMReadEnable  <= ON;
                            oMWriteEnable <= OFF;
                            oMByteEnable  <= ALL_LANES;
                        end
                    end
                end
                I_ACCESS, D_ACCESS: begin
                    if (iMReady || expire) begin
                        state         <= IDLE;
                        oMReadEnable  <= OFF;
                        oMWriteEnable <= OFF;
                        oMByteEnable  <= NO_LANES;
                        oBusError     <= !iMReady;
                        if (state == I_ACCESS) begin
                            oIAck      <= ON;
                            oIReadData <= iMReady ? selectWord(iMReadData, oMAddress[2]) : 32'd0;
                        end else begin
                            oDAck <= ON;
                            if (iMReady && !oMWriteEnable) oDReadData <= iMReadData;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus reset, tie and back-to-back sequences.
module tb_mem_arbiter;

    logic        iCLK, iRST_N;
    logic        iIReq, iDReq, iDWrite, iMReady;
    logic [63:0] iIAddress, iDAddress, iDWriteData, iMReadData;
    logic [7:0]  iDByteEnable;

    logic        oIAck, oDAck, oBusError, oMReadEnable, oMWriteEnable;
    logic [31:0] oIReadData;
    logic [63:0] oDReadData, oMAddress, oMWriteData;
    logic [7:0]  oMByteEnable;

    logic        rrIAck, rrDAck, rrBusError, rrMReadEnable, rrMWriteEnable;
    logic [31:0] rrIReadData;
    logic [63:0] rrDReadData, rrMAddress, rrMWriteData;
    logic [7:0]  rrMByteEnable;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iIReq(iIReq), .iIAddress(iIAddress), .oIAck(oIAck), .oIReadData(oIReadData),
        .iDReq(iDReq), .iDWrite(iDWrite), .iDAddress(iDAddress), .iDWriteData(iDWriteData),
        .iDByteEnable(iDByteEnable), .oDAck(oDAck), .oDReadData(oDReadData), .oBusError(oBusError),
        .oMReadEnable(oMReadEnable), .oMWriteEnable(oMWriteEnable), .oMAddress(oMAddress),
        .oMWriteData(oMWriteData), .oMByteEnable(oMByteEnable),
        .iMReadData(iMReadData), .iMReady(iMReady)
    );

    mem_arbiter #(.DATA_PRIORITY(0)) dutRr (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iIReq(iIReq), .iIAddress(iIAddress), .oIAck(rrIAck), .oIReadData(rrIReadData),
        .iDReq(iDReq), .iDWrite(iDWrite), .iDAddress(iDAddress), .iDWriteData(iDWriteData),
        .iDByteEnable(iDByteEnable), .oDAck(rrDAck), .oDReadData(rrDReadData), .oBusError(rrBusError),
        .oMReadEnable(rrMReadEnable), .oMWriteEnable(rrMWriteEnable), .oMAddress(rrMAddress),
        .oMWriteData(rrMWriteData), .oMByteEnable(rrMByteEnable),
        .iMReadData(iMReadData), .iMReady(iMReady)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    typedef struct {
        logic        isData;
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] mrd;
        int          delay;   // cycles before iMReady rises; -1 = never (timeout)
        logic [63:0] expRd;
        logic [7:0]  expBe;
        logic        expErr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic pulseReset();
        iRST_N = 1'b0;
        iIReq = 1'b0; iDReq = 1'b0; iMReady = 1'b0;
        step();
        iRST_N = 1'b1;
    endtask

    task automatic runVec(input vec_t v, input int idx);
        int  n;
        logic done;
        int  expLat;
        logic isWr;
        isWr = v.isData && v.write;
        iIReq = !v.isData; iDReq = v.isData; iDWrite = v.write;
        iIAddress = v.addr; iDAddress = v.addr; iDWriteData = v.wdata;
        iDByteEnable = v.be; iMReadData = v.mrd; iMReady = 1'b0;
        step();
        check($sformatf("v%0d mre", idx), 64'(oMReadEnable), 64'(!isWr));
        check($sformatf("v%0d mwe", idx), 64'(oMWriteEnable), 64'(isWr));
        check($sformatf("v%0d mbe", idx), 64'(oMByteEnable), 64'(v.expBe));
        check($sformatf("v%0d maddr", idx), oMAddress, v.addr);
        if (isWr) check($sformatf("v%0d mwdata", idx), oMWriteData, v.wdata);
        iMReady = (v.delay == 0);
        n = 0; done = 1'b0;
        while (!done && n < 40) begin
            step();
            n++;
            if (oIAck || oDAck) done = 1'b1;
            else if (n == v.delay) iMReady = 1'b1;
        end
        expLat = (v.delay < 0) ? 15 : v.delay + 1;
        check($sformatf("v%0d latency", idx), 64'(n), 64'(expLat));
        check($sformatf("v%0d iack", idx), 64'(oIAck), 64'(!v.isData));
        check($sformatf("v%0d dack", idx), 64'(oDAck), 64'(v.isData));
        check($sformatf("v%0d buserr", idx), 64'(oBusError), 64'(v.expErr));
        check($sformatf("v%0d rdata", idx), v.isData ? oDReadData : {32'd0, oIReadData}, v.expRd);
        check($sformatf("v%0d idle be", idx), 64'(oMByteEnable), 64'd0);
        iIReq = 1'b0; iDReq = 1'b0; iMReady = 1'b0;
        step();
        check($sformatf("v%0d ack drop", idx), 64'({oIAck, oDAck, oBusError}), 64'd0);
    endtask

    initial begin
        logic expFirst, expSecond;
        vecs[0] = '{1'b0, 1'b0, 64'h404,  64'h0,    8'h00, 64'hAAAA_BBBB_CCCC_DDDD,  0, 64'hAAAABBBB,            8'hFF, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 64'h400,  64'h0,    8'h00, 64'hAAAA_BBBB_CCCC_DDDD,  2, 64'hCCCCDDDD,            8'hFF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 64'h2000, 64'h0,    8'h00, 64'h0123_4567_89AB_CDEF,  0, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 64'h1008, 64'h1234, 8'h0F, 64'hDEAD_BEEF_DEAD_BEEF,  1, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 64'h408,  64'h0,    8'h00, 64'h1111_2222_3333_4444, -1, 64'h0,                   8'hFF, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 64'h3000, 64'h0,    8'hF0, 64'h5555_5555_5555_5555, -1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 64'h10,   64'h0,    8'h00, 64'hFEDC_BA98_7654_3210,  3, 64'hFEDC_BA98_7654_3210, 8'hFF, 1'b0};

        iRST_N = 1'b0;
        iIReq = 1'b0; iDReq = 1'b0; iDWrite = 1'b0; iMReady = 1'b0;
        iIAddress = 64'd0; iDAddress = 64'd0; iDWriteData = 64'd0; iMReadData = 64'd0; iDByteEnable = 8'd0;
        #3;
        check("rst acks", 64'({oIAck, oDAck, oBusError}), 64'd0);
        check("rst enables", 64'({oMReadEnable, oMWriteEnable}), 64'd0);
        check("rst mbe", 64'(oMByteEnable), 64'd0);
        check("rst maddr", oMAddress, 64'd0);
        check("rst ird", 64'(oIReadData), 64'd0);
        check("rst drd", oDReadData, 64'd0);
        step();
        iRST_N = 1'b1;
        step();

        for (int i = 0; i < 7; i++) runVec(vecs[i], i);

        // reset in the middle of a data access
        iDReq = 1'b1; iDWrite = 1'b1; iDAddress = 64'h40; iDByteEnable = 8'h3C; iDWriteData = 64'h77;
        iMReady = 1'b0;
        step();
        check("midrst mwe before", 64'(oMWriteEnable), 64'd1);
        #2 iRST_N = 1'b0;
        #1;
        check("midrst enables", 64'({oMReadEnable, oMWriteEnable}), 64'd0);
        check("midrst mbe", 64'(oMByteEnable), 64'd0);
        check("midrst maddr", oMAddress, 64'd0);
        check("midrst drd", oDReadData, 64'd0);
        iDReq = 1'b0;
        step();
        iRST_N = 1'b1;
        iMReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("midrst noack c%0d", c), 64'({oIAck, oDAck, oMReadEnable, oMWriteEnable}), 64'd0);
        end
        iMReady = 1'b0;
        runVec(vecs[0], 10);

        // both ports held, memory always ready: priority dut and round-robin dut
        pulseReset();
        iIReq = 1'b1; iDReq = 1'b1; iDWrite = 1'b0; iMReady = 1'b1;
        iIAddress = 64'h404; iDAddress = 64'h800; iMReadData = 64'h1;
        for (int c = 1; c <= 8; c++) begin
            step();
            expFirst  = (c % 2 == 0) && ((c / 2) % 2 == 1);
            expSecond = (c % 2 == 0) && ((c / 2) % 2 == 0);
            check($sformatf("tie pri dack c%0d", c), 64'(oDAck),  64'(expFirst));
            check($sformatf("tie pri iack c%0d", c), 64'(oIAck),  64'(expSecond));
            check($sformatf("tie rr iack c%0d", c),  64'(rrIAck), 64'(expFirst));
            check($sformatf("tie rr dack c%0d", c),  64'(rrDAck), 64'(expSecond));
        end

        // fetch held through its ack: one-cycle gap, no double ack
        pulseReset();
        iIReq = 1'b1; iDReq = 1'b0; iMReady = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            check($sformatf("b2b iack c%0d", c), 64'(oIAck), 64'(c % 3 == 2));
            check($sformatf("b2b dack c%0d", c), 64'(oDAck), 64'd0);
        end
        iIReq = 1'b0; iMReady = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_PRIORITY, default 1, 1 = data port wins simultaneous requests; 0 = round-robin between ports.
REQ-002 Parameter MAX_WAIT, default 15, maximum ACCESS cycles without iMReady before abort; legal range 1..255.
REQ-003 iCLK  in  1  single clock; all state changes on rising edge.
REQ-004 iRST_N  in  1  reset, asynchronous, active-low.
REQ-005 iIReq  in  1  instruction fetch request, held high until oIAck.
REQ-006 iIAddress  in  64  fetch byte address, word-aligned.
REQ-007 oIAck  out  1  one-cycle fetch completion pulse.
REQ-008 oIReadData  out  32  fetched instruction, valid from oIAck cycle until next oIAck.
REQ-009 iDReq, iDWrite  in  1 each  data request and write (1) / read (0) select, held until oDAck.
REQ-010 iDAddress, iDWriteData  in  64 each  data address and store data.
REQ-011 iDByteEnable  in  8  store byte lanes.
REQ-012 oDAck  out  1  one-cycle data completion pulse; oDReadData  out  64  load data.
REQ-013 oBusError  out  1  high with the ack of an aborted access.
REQ-014 oMReadEnable, oMWriteEnable  out  1 each; oMAddress, oMWriteData  out  64 each; oMByteEnable  out  8  shared memory port.
REQ-015 iMReadData  in  64; iMReady  in  1  memory completes the access in the cycle it is high.

Function
REQ-016 FSM states IDLE, I_ACCESS, D_ACCESS; one access in flight at a time.
REQ-017 IDLE: no request -> stay; only iIReq -> I_ACCESS; only iDReq -> D_ACCESS; both -> per DATA_PRIORITY/round-robin.
REQ-018 Round-robin: grant the port not granted most recently; pointer updates on every grant.
REQ-019 A port whose ack is high in the current cycle is masked from arbitration in that cycle.
REQ-020 On grant, address, write data, byte enables and direction are registered; memory outputs driven only from these registers.
REQ-021 I_ACCESS: oMReadEnable=1, oMWriteEnable=0, oMByteEnable=8'hFF, oMAddress = registered fetch address.
REQ-022 D_ACCESS: oMReadEnable=~write, oMWriteEnable=write, oMByteEnable = registered byte enables (8'hFF on read).
REQ-023 In IDLE all memory enables and oMByteEnable are 0.
REQ-024 iMReady sampled high in an ACCESS state -> return to IDLE; corresponding ack high the following cycle for exactly one cycle.
REQ-025 Fetch data: oIReadData = iMReadData[63:32] if address bit 2 = 1, else [31:0], captured at the iMReady edge.
REQ-026 Data read: oDReadData captured from iMReadData at the iMReady edge; unchanged on writes and aborts.
REQ-027 Minimum latency: request high in cycle 0 -> memory enable cycle 1 -> ack cycle 2 when iMReady high in cycle 1.
REQ-028 Wait counter clears on grant and increments each ACCESS cycle without iMReady; reaching MAX_WAIT -> IDLE, ack + oBusError pulse, oIReadData cleared to 0 on a fetch abort.
REQ-029 Request deasserted mid-access: access still completes and acks; ack is ignored by requester.
REQ-030 iMReady while IDLE is ignored.

Reset
REQ-031 iRST_N low asynchronously forces IDLE, all outputs 0, wait counter 0, round-robin pointer "last = data" (instruction wins first tie).
REQ-032 Reset asserted mid-access aborts the access without ack; first request after release re-arbitrates from IDLE.

Structure
REQ-033 State encodings and ON/OFF constants live in the shared Parametros.v package.
REQ-034 Single sub-module ARB_WAIT_TIMER (clear, enable, MAX_WAIT compare, expire output); all other logic inline.

Verification
REQ-035 Fetch: iIReq, iIAddress=0x404, iMReady immediate, iMReadData=0xAAAA_BBBB_CCCC_DDDD -> oIAck cycle 2, oIReadData=0xAAAABBBB.
REQ-036 Store: iDWrite=1, iDAddress=0x1008, iDByteEnable=0x0F, data 0x1234 -> oMWriteEnable=1, oMByteEnable=0x0F, oDAck, oDReadData unchanged.
REQ-037 Tie, DATA_PRIORITY=1: both requests held -> D granted first, then I; with DATA_PRIORITY=0 -> I, D, I, D alternation.
REQ-038 Timeout: iMReady held 0, MAX_WAIT=15 -> ack with oBusError=1 after 15 ACCESS cycles, return to IDLE.
REQ-039 Reset mid D_ACCESS: iRST_N low 1 cycle -> all outputs 0 immediately, no oDAck, new request served normally afterwards.
REQ-040 Back-to-back: iIReq held through ack -> masked in ack cycle, re-granted next cycle, no double ack.
